// File: rtl/uart_fifo_param.sv
// uart_fifo_param: parametrised synchronous FIFO for the UART16550 TX holding
// and RX paths. First-word-fall-through read, live fill level, synchronous
// flush and enable, overrun/underrun pulses and a programmable threshold flag.
//
// Optional feature: define UART_FIFO_ERRTAG_EN to store a per-entry error tag
// (rd_err) and track whether any stored entry is tagged (err_in_fifo).
// Without it, err_in is ignored and rd_err/err_in_fifo are tied to 0.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en, flush           en=0 or flush=1 empties the FIFO this cycle
//   push_in, din,err_in write request, data and error tag
//   pop_in              read request (advances head)
//   dout, rd_err        head entry and its tag, 0 while empty
//   empty, full, level  status derived from the registered fill level
//   overrun, underrun   one-cycle pulses after a rejected push/pop
//   threshold           trigger level (0 disables thre_trigger)
//   thre_trigger        level >= threshold
//   err_in_fifo         at least one stored entry carries an error tag
module uart_fifo_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [DATA_W-1:0]          din,
  input  logic                       err_in,
  output logic [DATA_W-1:0]          dout,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       underrun,
  input  logic [$clog2(DEPTH):0]     threshold,
  output logic                       thre_trigger,
  output logic                       err_in_fifo
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0]   ONE_LVL  = 1;
  localparam logic [AW-1:0] ONE_PTR  = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;

  logic run;
  logic pop_acc;
  logic push_acc;
  logic wr_en;

  always_comb begin
    run      = en && !flush;
    pop_acc  = run && pop_in && (level_q != '0);
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    push_acc = run && push_in && ((level_q != FULL_LVL) || pop_acc);
    wr_en    = push_acc && !rst;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    if (!run) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE_PTR;
      case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + ONE_LVL;
        2'b01:   level_d = level_q - ONE_LVL;
        default: level_d = level_q;
      endcase
      overrun_d  = push_in && !push_acc;
      underrun_d = pop_in && !pop_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is not reset; contents are only visible through the empty gate.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    empty        = (level_q == '0);
    full         = (level_q == FULL_LVL);
    level        = level_q;
    overrun      = overrun_q;
    underrun     = underrun_q;
    dout         = empty ? '0 : mem_q[rd_ptr_q];
    thre_trigger = (threshold != '0) && (level_q >= threshold);
  end

`ifdef UART_FIFO_ERRTAG_EN
  logic          tag_q [DEPTH];
  logic [AW:0]   errcnt_q, errcnt_d;
  logic          head_tag;

  always_comb begin
    head_tag = tag_q[rd_ptr_q];
    errcnt_d = errcnt_q;
    if (!run) begin
      errcnt_d = '0;
    end else begin
      // Tagged push and tagged pop in the same cycle cancel out.
      case ({push_acc && err_in, pop_acc && head_tag})
        2'b10:   errcnt_d = errcnt_q + ONE_LVL;
        2'b01:   errcnt_d = errcnt_q - ONE_LVL;
        default: errcnt_d = errcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_ptr_q] <= err_in;
  end

  always_comb begin
    rd_err      = empty ? 1'b0 : head_tag;
    err_in_fifo = (errcnt_q != '0);
  end
`else
  logic unused_err_in;

  always_comb begin
    unused_err_in = err_in;
    rd_err        = 1'b0;
    err_in_fifo   = 1'b0;
  end
`endif

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
Parametrised successor to the fixed 16x8 UART FIFO, used for both the TX holding FIFO and the RX FIFO of the UART16550 core. It adds configurable width and depth, a live fill level and a synchronous flush. It also defines full-with-pop and empty-with-push behaviour and an optional per-entry error tag for the RX "error in FIFO" status. The write side is driven by the register interface (TX) or the receiver (RX); the read side is driven by the transmitter (TX) or the register interface (RX).

Parameters:
DATA_W, 8, payload width in bits.
DEPTH, 16, number of entries; must be a power of two and at least 2. Derived localparam AW = $clog2(DEPTH).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  FIFO enable; 0 behaves as a continuous flush
flush  in  1  synchronous clear of contents, one-cycle pulse
push_in  in  1  write request
pop_in  in  1  read request
din  in  DATA_W  write data
err_in  in  1  error tag stored with din (RX parity/framing/break)
dout  out  DATA_W  head entry, first-word-fall-through
rd_err  out  1  error tag of the head entry
empty  out  1  level == 0
full  out  1  level == DEPTH
level  out  AW+1  current number of stored entries
overrun  out  1  one-cycle pulse: push rejected
underrun  out  1  one-cycle pulse: pop rejected
threshold  in  AW+1  trigger level
thre_trigger  out  1  threshold reached
err_in_fifo  out  1  at least one stored entry carries an error tag

Behaviour:
- Reset and clear: rst is sampled on the rising edge of clk. It sets read and write pointers to 0, level=0, overrun=0, underrun=0 and the error counter to 0. After reset: empty=1, full=0, dout=0, rd_err=0, thre_trigger=0, err_in_fifo=0. Memory contents are not reset.
- Priority per cycle: rst, then (!en or flush), then push/pop. !en or flush clears pointers, level and the error counter exactly as reset does, and produces no overrun or underrun pulse.
- Accepted pop: pop_acc = pop_in && level != 0.
- Accepted push: push_acc = push_in && (level != DEPTH || pop_acc). A push while full is accepted when a pop is accepted in the same cycle.
- Level update: level increments on push_acc only, decrements on pop_acc only, and is unchanged when both or neither occur.
- Pointers: AW bits each and wrap naturally. The write pointer advances on push_acc; the read pointer advances on pop_acc. din and err_in are written at the write pointer on push_acc.
- Overrun: push_in while full without pop_acc drops the data and leaves contents unchanged. overrun is high for exactly the next cycle.
- Underrun: pop_in while empty is ignored and underrun is high for the next cycle. A simultaneous push is still accepted.
- Flag timing: empty, full and level come from the level register and update in the cycle after the edge that changed it. A push into an empty FIFO makes dout valid in that same following cycle, giving 1-cycle write-to-read latency.
- Output gating: dout and rd_err are combinational reads of the head entry, forced to 0 while empty.
- thre_trigger = (threshold != 0) && (level >= threshold), combinational. A threshold greater than DEPTH never triggers.
- No back-to-back restriction: push and pop may be asserted every cycle.

Optional Feature:
Macro UART_FIFO_ERRTAG_EN.
- Defined:
  - Each entry stores an extra tag bit, and rd_err reports the head tag.
  - An error counter (AW+1 bits) increments on push_acc with err_in=1 and decrements on pop_acc of a head entry with tag=1; both in the same cycle leave it unchanged.
  - err_in_fifo = (counter != 0).
- Undefined: the tag bit is not stored, the counter is absent, err_in is ignored, and rd_err and err_in_fifo are tied to 0.

Test Plan:
- Fill and drain: DEPTH=16, DATA_W=8, en=1. Push 0x00..0x0F on 16 consecutive cycles -> full=1 and level=16. Then pop 16 times -> dout shows 0x00..0x0F in order, empty=1 after the last pop, no overrun or underrun pulses.
- Overrun: with the FIFO full, push 0xAA without pop -> overrun high for 1 cycle, level stays 16, and the next 16 pops never return 0xAA. Repeat with pop_in=1 in the same cycle -> no overrun, level=16, 0xAA becomes the tail entry.
- Underrun: on an empty FIFO, pop alone -> underrun high for 1 cycle, level 0. Then pop plus push of 0x55 in one cycle -> underrun pulse, level=1, dout=0x55.
- Threshold: threshold=4. Pushes 1..4 -> thre_trigger rises the cycle level reaches 4; one pop -> it falls. With threshold=0, a fill to 16 never raises thre_trigger.
- Flush and reset: with 7 entries stored, pulse flush together with push -> level=0, empty=1, dout=0, no overrun. Hold en=0 and push 3 entries -> level stays 0. Assert rst mid-drain -> all outputs return to reset values on the next cycle.
- Error tag (macro on): push 0x11 with err_in=0, 0x22 with err_in=1, 0x33 with err_in=0 -> err_in_fifo=1. Pop 0x11 -> rd_err=1 with dout=0x22. Pop 0x22 -> err_in_fifo=0. With the macro off, rd_err and err_in_fifo stay 0 throughout.
